// File: rtl/bf_bus_ctrl.sv
// bf_bus_ctrl: serialises BF CPU memory/IO requests into byte phases on an 8-bit rdy/ack bus.
// Optional feature: define BF_BUS_ADDR_CACHE_EN to skip the ADDR phases when the data address repeats.
module bf_bus_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        mreq,
  input  logic [2:0]  mtype,
  output logic        mdone,
  input  logic        ack,
  output logic        rdy,
  output logic [1:0]  bus_ctrl,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR0 = 3'd2;
  localparam logic [2:0] S_ADDR1 = 3'd3;
  localparam logic [2:0] S_ADDR2 = 3'd4;
  localparam logic [2:0] S_XFER  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] CTRL_CMD   = 2'b00;
  localparam logic [1:0] CTRL_ADDR  = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b10;
  localparam logic [1:0] CTRL_READ  = 2'b11;

  localparam logic [2:0] T_PROGN = 3'd0;
  localparam logic [2:0] T_PROGP = 3'd1;
  localparam logic [2:0] T_RDATA = 3'd2;
  localparam logic [2:0] T_WDATA = 3'd3;
  localparam logic [2:0] T_RCHAR = 3'd4;
  localparam logic [2:0] T_WCHAR = 3'd5;

  logic [2:0]             state;
  logic                   armed;
  logic [2:0]             type_q;
  logic [23:0]            addr_q;
  logic [7:0]             wdata_q;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   addr_hit;
  logic                   has_addr;
  logic                   is_read;
  logic                   is_write;
  logic [1:0]             xfer_ctrl;
  logic [7:0]             xfer_out;

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign has_addr  = (type_q == T_RDATA) || (type_q == T_WDATA);
  assign is_write  = (type_q == T_WDATA) || (type_q == T_WCHAR);
  assign is_read   = (type_q == T_PROGN) || (type_q == T_PROGP) ||
                     (type_q == T_RDATA) || (type_q == T_RCHAR);
  assign xfer_ctrl = is_write ? CTRL_WRITE : CTRL_READ;
  assign xfer_out  = is_write ? wdata_q : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
  end

`ifdef BF_BUS_ADDR_CACHE_EN
  logic [23:0] last_addr;
  logic        addr_valid;

  // The cache is only refreshed once the last ADDR byte has been fully handshaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr  <= '0;
      addr_valid <= 1'b0;
    end else if (state == S_ADDR2 && !rdy && !ack_s) begin
      last_addr  <= addr_q;
      addr_valid <= 1'b1;
    end
  end

  assign addr_hit = addr_valid && (addr_q == last_addr);
`else
  assign addr_hit = 1'b0;
`endif

  // rdy doubles as the handshake sub-phase: high waits for ack rise, low waits for ack fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      armed    <= 1'b1;
      type_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdy      <= 1'b0;
      mdone    <= 1'b0;
      bus_ctrl <= CTRL_CMD;
      bus_out  <= '0;
      data_out <= '0;
    end else begin
      mdone <= 1'b0;
      if (!mreq) armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (mreq && armed && !ack_s) begin
            type_q   <= mtype;
            addr_q   <= addr;
            wdata_q  <= data_in;
            bus_out  <= {5'b0, mtype};
            bus_ctrl <= CTRL_CMD;
            rdy      <= 1'b1;
            state    <= S_CMD;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (rdy) begin
            if (ack_s) begin
              rdy <= 1'b0;
              if (bus_ctrl == CTRL_READ) data_out <= bus_in;
            end
          end else if (!ack_s) begin
            case (state)
              S_CMD: begin
                if (has_addr && !addr_hit) begin
                  bus_out  <= addr_q[7:0];
                  bus_ctrl <= CTRL_ADDR;
                  rdy      <= 1'b1;
                  state    <= S_ADDR0;
                end else if (is_read || is_write) begin
                  bus_out  <= xfer_out;
                  bus_ctrl <= xfer_ctrl;
                  rdy      <= 1'b1;
                  state    <= S_XFER;
                end else begin
                  mdone <= 1'b1;
                  armed <= 1'b0;
                  state <= S_DONE;
                end
              end
              S_ADDR0: begin
                bus_out  <= addr_q[15:8];
                bus_ctrl <= CTRL_ADDR;
                rdy      <= 1'b1;
                state    <= S_ADDR1;
              end
              S_ADDR1: begin
                bus_out  <= addr_q[23:16];
                bus_ctrl <= CTRL_ADDR;
                rdy      <= 1'b1;
                state    <= S_ADDR2;
              end
              S_ADDR2: begin
                bus_out  <= xfer_out;
                bus_ctrl <= xfer_ctrl;
                rdy      <= 1'b1;
                state    <= S_XFER;
              end
              S_XFER: begin
                mdone <= 1'b1;
                armed <= 1'b0;
                state <= S_DONE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Directed testbench for bf_bus_ctrl; acts as the CPU and as the external bus host.
// Expectations follow BF_BUS_ADDR_CACHE_EN when it is defined for the build.
module tb_bf_bus_ctrl;

  localparam logic [1:0] C_CMD   = 2'b00;
  localparam logic [1:0] C_ADDR  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic [23:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        mreq;
  logic [2:0]  mtype;
  logic        mdone;
  logic        ack;
  logic        rdy;
  logic [1:0]  bus_ctrl;
  logic [7:0]  bus_in;
  logic [7:0]  bus_out;

  int total = 0;
  int bad   = 0;

  bf_bus_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .data_out(data_out),
    .mreq(mreq), .mtype(mtype), .mdone(mdone), .ack(ack), .rdy(rdy),
    .bus_ctrl(bus_ctrl), .bus_in(bus_in), .bus_out(bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input logic level, input string tag);
    int n;
    n = 0;
    while (rdy !== level && n < 300) begin
      @(negedge clk);
      n++;
    end
    check8({tag, " rdy"}, 8'(rdy), 8'(level));
  endtask

  // One full host handshake; dly stretches each ack edge and checks the bus holds meanwhile.
  task automatic do_phase(input string tag, input logic [1:0] exp_ctrl, input logic chk_out,
                          input logic [7:0] exp_out, input logic [7:0] rdata, input int dly);
    wait_rdy(1'b1, tag);
    check8({tag, " ctrl"}, 8'(bus_ctrl), 8'(exp_ctrl));
    if (chk_out) check8({tag, " out"}, bus_out, exp_out);
    bus_in = rdata;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check8({tag, " hold"}, {5'b0, rdy, bus_ctrl}, {5'b0, 1'b1, exp_ctrl});
      if (chk_out) check8({tag, " hold out"}, bus_out, exp_out);
    end
    ack = 1'b1;
    wait_rdy(1'b0, tag);
    repeat (dly) @(negedge clk);
    ack = 1'b0;
    bus_in = 8'hee;
  endtask

  task automatic wait_mdone(input string tag);
    int n;
    n = 0;
    while (mdone !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check8({tag, " mdone"}, 8'(mdone), 8'd1);
    @(negedge clk);
    check8({tag, " mdone pulse"}, 8'(mdone), 8'd0);
  endtask

  task automatic start_tx(input logic [2:0] t, input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    mtype   = t;
    addr    = a;
    data_in = d;
    mreq    = 1'b1;
  endtask

  task automatic end_tx(input string tag, input int hold);
    wait_mdone(tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check8({tag, " no rerun"}, 8'(rdy), 8'd0);
    end
    mreq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mreq = 1'b0; mtype = 3'd0; addr = '0; data_in = '0;
    ack = 1'b0; bus_in = 8'h00;
    #1;
    check8("reset rdy", 8'(rdy), 8'd0);
    check8("reset mdone", 8'(mdone), 8'd0);
    check8("reset data_out", data_out, 8'h00);
    #20 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // PROGN fetch; mreq lingers two cycles after mdone
    start_tx(3'd0, 24'h0, 8'h00);
    @(negedge clk);
    check8("t2 rdy latency", 8'(rdy), 8'd1);
    do_phase("t2 cmd", C_CMD, 1'b1, 8'h00, 8'h00, 0);
    do_phase("t2 rd", C_READ, 1'b0, 8'h00, 8'h2b, 0);
    end_tx("t2", 2);
    check8("t2 data_out", data_out, 8'h2b);

    // Reset in the middle of a CMD phase clears outputs without a clock edge
    start_tx(3'd1, 24'h0, 8'h00);
    wait_rdy(1'b1, "t1 pre");
    check8("t1 cmd out", bus_out, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check8("t1 rdy async", 8'(rdy), 8'd0);
    check8("t1 ctrl async", 8'(bus_ctrl), 8'd0);
    check8("t1 out async", bus_out, 8'h00);
    check8("t1 data_out async", data_out, 8'h00);
    mreq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check8("t1 idle mdone", 8'(mdone), 8'd0);
      check8("t1 idle rdy", 8'(rdy), 8'd0);
    end

    // WDATA with data_in changed after launch to prove it was latched
    start_tx(3'd3, 24'h001234, 8'h7f);
    do_phase("t3 cmd", C_CMD, 1'b1, 8'h03, 8'h00, 0);
    data_in = 8'h00;
    do_phase("t3 a0", C_ADDR, 1'b1, 8'h34, 8'h00, 0);
    do_phase("t3 a1", C_ADDR, 1'b1, 8'h12, 8'h00, 0);
    do_phase("t3 a2", C_ADDR, 1'b1, 8'h00, 8'h00, 0);
    do_phase("t3 wr", C_WRITE, 1'b1, 8'h7f, 8'h00, 0);
    end_tx("t3", 1);
    check8("t3 data_out kept", data_out, 8'h00);

    // Slow host, mreq withdrawn during ADDR1
    start_tx(3'd2, 24'h123456, 8'h00);
    do_phase("t4 cmd", C_CMD, 1'b1, 8'h02, 8'h00, 10);
    do_phase("t4 a0", C_ADDR, 1'b1, 8'h56, 8'h00, 10);
    wait_rdy(1'b1, "t4 a1 pre");
    mreq = 1'b0;
    do_phase("t4 a1", C_ADDR, 1'b1, 8'h34, 8'h00, 10);
    do_phase("t4 a2", C_ADDR, 1'b1, 8'h12, 8'h00, 10);
    do_phase("t4 rd", C_READ, 1'b0, 8'h00, 8'h99, 10);
    wait_mdone("t4");
    check8("t4 data_out", data_out, 8'h99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check8("t4 single mdone", {6'b0, mdone, rdy}, 8'd0);
    end

    // RCHAR then WCHAR; the write phase must not disturb data_out
    start_tx(3'd4, 24'h0, 8'h00);
    do_phase("t5 rc cmd", C_CMD, 1'b1, 8'h04, 8'h00, 0);
    do_phase("t5 rc rd", C_READ, 1'b0, 8'h00, 8'h41, 0);
    end_tx("t5 rc", 1);
    check8("t5 rc data_out", data_out, 8'h41);
    start_tx(3'd5, 24'h0, 8'h41);
    do_phase("t5 wc cmd", C_CMD, 1'b1, 8'h05, 8'h00, 0);
    do_phase("t5 wc wr", C_WRITE, 1'b1, 8'h41, 8'hee, 0);
    end_tx("t5 wc", 1);
    check8("t5 wc data_out", data_out, 8'h41);

    // Reserved mtype 6: CMD phase only
    start_tx(3'd6, 24'h0, 8'h00);
    do_phase("t7 cmd", C_CMD, 1'b1, 8'h06, 8'hee, 0);
    end_tx("t7", 1);
    check8("t7 data_out kept", data_out, 8'h41);

    // Address cache behaviour (or three ADDR phases every time without it)
    start_tx(3'd2, 24'h000010, 8'h00);
    do_phase("t6a cmd", C_CMD, 1'b1, 8'h02, 8'h00, 0);
    do_phase("t6a a0", C_ADDR, 1'b1, 8'h10, 8'h00, 0);
    do_phase("t6a a1", C_ADDR, 1'b1, 8'h00, 8'h00, 0);
    do_phase("t6a a2", C_ADDR, 1'b1, 8'h00, 8'h00, 0);
    do_phase("t6a rd", C_READ, 1'b0, 8'h00, 8'h5a, 0);
    end_tx("t6a", 1);
    check8("t6a data_out", data_out, 8'h5a);
    start_tx(3'd2, 24'h000010, 8'h00);
    do_phase("t6b cmd", C_CMD, 1'b1, 8'h02, 8'h00, 0);
`ifndef BF_BUS_ADDR_CACHE_EN
    do_phase("t6b a0", C_ADDR, 1'b1, 8'h10, 8'h00, 0);
    do_phase("t6b a1", C_ADDR, 1'b1, 8'h00, 8'h00, 0);
    do_phase("t6b a2", C_ADDR, 1'b1, 8'h00, 8'h00, 0);
`endif
    do_phase("t6b rd", C_READ, 1'b0, 8'h00, 8'h5b, 0);
    end_tx("t6b", 1);
    check8("t6b data_out", data_out, 8'h5b);
    start_tx(3'd2, 24'h000011, 8'h00);
    do_phase("t6c cmd", C_CMD, 1'b1, 8'h02, 8'h00, 0);
    do_phase("t6c a0", C_ADDR, 1'b1, 8'h11, 8'h00, 0);
    do_phase("t6c a1", C_ADDR, 1'b1, 8'h00, 8'h00, 0);
    do_phase("t6c a2", C_ADDR, 1'b1, 8'h00, 8'h00, 0);
    do_phase("t6c rd", C_READ, 1'b0, 8'h00, 8'h5c, 0);
    end_tx("t6c", 1);
    check8("t6c data_out", data_out, 8'h5c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
